spi_word_sequencer: RTL and testbench
=====================================

# spi_word_sequencer

Burst sequencer between the host-facing register/bus side and the SpiBase shift engine. Buffers outgoing words in a send FIFO, launches them one at a time into SpiBase via its start/ready handshake, captures each received word into a receive FIFO, and drives nCS across a back-to-back burst. It is the stage directly upstream of SpiBase: it feeds SpiBase's start and sendData and consumes SpiBase's recvData.

## Interface
- MAX_WORD_SIZE, 32, width of data words; matches the SpiBase instance.
- FIFO_DEPTH, 8, entries per FIFO; power of two, at least 2.
- ALMOST_FULL_LEVEL, 6, count at or above which an almost-full flag is set.
- ALMOST_EMPTY_LEVEL, 2, count at or below which an almost-empty flag is set.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- nReset  in  1  asynchronous, active-low reset.
- enable  in  1  permits launching new words; an in-flight word always completes.
- busy  out  1  high whenever the FSM is not IDLE.
- nCS  out  1  chip select, active low.
- push  in  1  write sendData into the send FIFO.
- sendData  in  MAX_WORD_SIZE  word to transmit.
- fullSendFifo, emptySendFifo, almostFullSendFifo, almostEmptySendFifo  out  1 each  send FIFO status.
- pop  in  1  remove the head of the receive FIFO.
- recvData  out  MAX_WORD_SIZE  receive FIFO head, first-word-fall-through.
- fullRecvFifo, emptyRecvFifo, almostFullRecvFifo, almostEmptyRecvFifo  out  1 each  receive FIFO status.
- spiStart  out  1  one-cycle start pulse to SpiBase.
- spiSendData  out  MAX_WORD_SIZE  word presented to SpiBase; held stable until the next launch.
- spiReady  in  1  SpiBase is idle. Low while shifting; rising edge means spiRecvData is valid.
- spiRecvData  in  MAX_WORD_SIZE  word received by SpiBase.

## Operation
- **FIFOs:** circular buffer with a count register of width log2(FIFO_DEPTH)+1.
  - Push when full is ignored.
  - Pop when empty is ignored; recvData holds its value.
  - Simultaneous push and pop on a non-empty, non-full FIFO leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Flags are registered from the count.
- **FSM states:** IDLE, SETUP, LAUNCH, WAIT_BUSY, WAIT_DONE, STORE.
  - **IDLE → SETUP** when enable && !emptySendFifo && !fullRecvFifo && spiReady. nCS goes low on entry to SETUP.
  - **SETUP → LAUNCH** after exactly 1 cycle (CS setup time).
  - **LAUNCH:**
    - spiStart = 1 for this single cycle.
    - spiSendData is registered from the send FIFO head.
    - The send FIFO is popped.
    - Always → WAIT_BUSY.
  - **WAIT_BUSY → WAIT_DONE** when spiReady == 0.
  - **WAIT_DONE → STORE** when spiReady == 1.
  - **STORE:**
    - Writes spiRecvData into the receive FIFO.
    - → LAUNCH if enable && !emptySendFifo && !fullRecvFifo, evaluated with the post-write count. nCS stays low for the burst.
    - Otherwise → IDLE, and nCS returns high on entry to IDLE.
- **No receive-data loss:** a word is launched only when the receive FIFO has a free slot. Only the sequencer writes that FIFO, so STORE never sees it full.
- **enable deasserted mid-word:** the current word runs to STORE and is stored, then the FSM goes to IDLE.
- **Host push during a burst:** extends the burst if the word is visible by the STORE cycle.

## Timing
- Reset values:
  - nCS = 1.
  - spiStart = 0, busy = 0.
  - spiSendData = 0, recvData = 0.
  - Both FIFOs empty: empty = 1, almostEmpty = 1, full = 0, almostFull = 0.
  - FSM in IDLE.
- **Reset mid-operation:** immediate return to the reset values. FIFO contents are discarded. SpiBase is expected to be reset by the same source.
- **Push latency:** push at edge N makes emptySendFifo = 0 after edge N+1. IDLE can leave at the edge after that.
- **Launch latency:** nCS falls 1 cycle before spiStart.
- **Store latency:** the receive FIFO count updates 1 cycle after spiReady rises (STORE cycle). emptyRecvFifo falls the cycle after.
- **Inter-word gap inside a burst:** spiReady rising → next spiStart = 2 cycles (STORE, LAUNCH).
- **End of burst:** nCS rises 1 cycle after the STORE cycle of the last word.
- **Stuck handshake:** spiReady never dropping after spiStart holds the FSM in WAIT_BUSY. No timeout.

## Test plan
- **Single word:** reset, enable=1, push 32'h8000BCA5, SpiBase with MISO looped to MOSI.
  - nCS low one cycle before a single spiStart.
  - Exactly one receive FIFO entry, recvData = 32'h8000BCA5.
  - nCS high afterwards, busy = 0.
- **Burst:** push 4 words (32'h1, 32'h2, 32'h3, 32'h4) before enable.
  - One continuous nCS-low window.
  - 4 spiStart pulses, each exactly 2 cycles after the previous spiReady rise.
  - Pops return 1, 2, 3, 4 in order.
- **Full/empty boundaries:** push FIFO_DEPTH+1 words with enable=0.
  - fullSendFifo = 1, count stays FIFO_DEPTH, extra word discarded.
  - almostFullSendFifo asserts at 6 entries.
  - pop on an empty receive FIFO leaves recvData unchanged.
- **Receive back-pressure:** never pop; push 10 words; enable.
  - Exactly 8 words transferred; receive FIFO full.
  - nCS high, FSM idle, send FIFO holds 2 words.
  - One pop → next word launched and stored.
- **Enable drop:** deassert enable during WAIT_DONE of word 1 of 3.
  - Word 1 stored, nCS rises, words 2 and 3 remain in the send FIFO.
  - Re-enable → both sent in a new burst.
- **Async reset mid-burst:** assert nReset during WAIT_DONE.
  - All outputs take reset values without waiting for a clock edge; both FIFOs empty.

Source files
------------

// File: rtl/spi_word_sequencer.sv
// Burst sequencer feeding a SpiBase shift engine: buffers host words in a send FIFO,
// launches them one at a time, and collects the received words in a receive FIFO.

module spi_word_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 8,
    parameter int AF    = 6,
    parameter int AE    = 2
) (
    input  logic                     clock,
    input  logic                     nReset,
    input  logic                     wr_en,
    input  logic [W-1:0]             wr_data,
    input  logic                     rd_en,
    output logic [W-1:0]             rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d, empty_q, empty_d;
    logic          afull_q, afull_d, aempty_q, aempty_d;
    logic          do_wr, do_rd;

    always_comb begin
        do_wr    = wr_en && (count_q != DEPTH_C);
        do_rd    = rd_en && (count_q != '0);
        wr_ptr_d = do_wr ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = do_rd ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(do_wr) - CW'(do_rd);
        // Flags trail the count by one cycle; the FSM relies on that push latency.
        full_d   = (count_q == DEPTH_C);
        empty_d  = (count_q == '0);
        afull_d  = (count_q >= CW'(AF));
        aempty_d = (count_q <= CW'(AE));
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
        end else begin
            if (do_wr) mem_q[wr_ptr_q] <= wr_data;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
        end
    end

    assign rd_data      = mem_q[rd_ptr_q];
    assign count        = count_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
endmodule

module spi_word_sequencer #(
    parameter int MAX_WORD_SIZE      = 32,
    parameter int FIFO_DEPTH         = 8,
    parameter int ALMOST_FULL_LEVEL  = 6,
    parameter int ALMOST_EMPTY_LEVEL = 2
) (
    input  logic                     clock,
    input  logic                     nReset,
    input  logic                     enable,
    output logic                     busy,
    output logic                     nCS,
    input  logic                     push,
    input  logic [MAX_WORD_SIZE-1:0] sendData,
    output logic                     fullSendFifo,
    output logic                     emptySendFifo,
    output logic                     almostFullSendFifo,
    output logic                     almostEmptySendFifo,
    input  logic                     pop,
    output logic [MAX_WORD_SIZE-1:0] recvData,
    output logic                     fullRecvFifo,
    output logic                     emptyRecvFifo,
    output logic                     almostFullRecvFifo,
    output logic                     almostEmptyRecvFifo,
    output logic                     spiStart,
    output logic [MAX_WORD_SIZE-1:0] spiSendData,
    input  logic                     spiReady,
    input  logic [MAX_WORD_SIZE-1:0] spiRecvData
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST_C  = CW'(FIFO_DEPTH - 1);

    typedef enum logic [2:0] {IDLE, SETUP, LAUNCH, WAIT_BUSY, WAIT_DONE, STORE} state_t;

    state_t                   state_q, state_d;
    logic [MAX_WORD_SIZE-1:0] spi_send_data_q, spi_send_data_d;
    logic [MAX_WORD_SIZE-1:0] send_head;
    logic [CW-1:0]            send_count, recv_count;
    logic                     recv_pop_eff, recv_full_after_store;

    spi_word_fifo #(
        .W(MAX_WORD_SIZE), .DEPTH(FIFO_DEPTH), .AF(ALMOST_FULL_LEVEL), .AE(ALMOST_EMPTY_LEVEL)
    ) u_send_fifo (
        .clock(clock), .nReset(nReset),
        .wr_en(push), .wr_data(sendData),
        .rd_en(state_q == LAUNCH), .rd_data(send_head),
        .count(send_count),
        .full(fullSendFifo), .empty(emptySendFifo),
        .almost_full(almostFullSendFifo), .almost_empty(almostEmptySendFifo)
    );

    spi_word_fifo #(
        .W(MAX_WORD_SIZE), .DEPTH(FIFO_DEPTH), .AF(ALMOST_FULL_LEVEL), .AE(ALMOST_EMPTY_LEVEL)
    ) u_recv_fifo (
        .clock(clock), .nReset(nReset),
        .wr_en(state_q == STORE), .wr_data(spiRecvData),
        .rd_en(pop), .rd_data(recvData),
        .count(recv_count),
        .full(fullRecvFifo), .empty(emptyRecvFifo),
        .almost_full(almostFullRecvFifo), .almost_empty(almostEmptyRecvFifo)
    );

    always_comb begin
        state_d         = state_q;
        spi_send_data_d = spi_send_data_q;
        // Receive count as it will stand after this STORE write (and any host pop).
        recv_pop_eff          = pop && (recv_count != '0);
        recv_full_after_store = (recv_count == LAUNCH_GUARD(LAST_C)) && !recv_pop_eff;
        case (state_q)
            IDLE:      if (enable && !emptySendFifo && (recv_count != DEPTH_C) && spiReady)
                           state_d = SETUP;
            SETUP:     state_d = LAUNCH;
            LAUNCH: begin
                spi_send_data_d = send_head;
                state_d         = WAIT_BUSY;
            end
            WAIT_BUSY: if (!spiReady) state_d = WAIT_DONE;
            WAIT_DONE: if (spiReady) state_d = STORE;
            STORE:     state_d = (enable && (send_count != '0) && !recv_full_after_store)
                                 ? LAUNCH : IDLE;
            default:   state_d = IDLE;
        endcase
    end

    function automatic logic [CW-1:0] LAUNCH_GUARD(input logic [CW-1:0] lvl);
        return lvl;
    endfunction

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state_q         <= IDLE;
            spi_send_data_q <= '0;
        end else begin
            state_q         <= state_d;
            spi_send_data_q <= spi_send_data_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign nCS         = (state_q == IDLE);
    assign spiStart    = (state_q == LAUNCH);
    assign spiSendData = spi_send_data_q;
endmodule

// File: tb/tb_spi_word_sequencer.sv
// Self-checking bench for spi_word_sequencer with a behavioural loopback SpiBase model.

module tb_spi_word_sequencer;
    localparam int W = 32;
    localparam int D = 8;

    logic         clock = 1'b0;
    logic         nReset = 1'b0;
    logic         enable = 1'b0;
    logic         push = 1'b0;
    logic         pop = 1'b0;
    logic [W-1:0] sendData = '0;
    logic         busy, nCS, spiStart;
    logic         fullSendFifo, emptySendFifo, almostFullSendFifo, almostEmptySendFifo;
    logic         fullRecvFifo, emptyRecvFifo, almostFullRecvFifo, almostEmptyRecvFifo;
    logic [W-1:0] recvData, spiSendData;
    logic         spiReady;
    logic [W-1:0] spiRecvData;

    spi_word_sequencer #(
        .MAX_WORD_SIZE(W), .FIFO_DEPTH(D), .ALMOST_FULL_LEVEL(6), .ALMOST_EMPTY_LEVEL(2)
    ) dut (
        .clock(clock), .nReset(nReset), .enable(enable), .busy(busy), .nCS(nCS),
        .push(push), .sendData(sendData),
        .fullSendFifo(fullSendFifo), .emptySendFifo(emptySendFifo),
        .almostFullSendFifo(almostFullSendFifo), .almostEmptySendFifo(almostEmptySendFifo),
        .pop(pop), .recvData(recvData),
        .fullRecvFifo(fullRecvFifo), .emptyRecvFifo(emptyRecvFifo),
        .almostFullRecvFifo(almostFullRecvFifo), .almostEmptyRecvFifo(almostEmptyRecvFifo),
        .spiStart(spiStart), .spiSendData(spiSendData),
        .spiReady(spiReady), .spiRecvData(spiRecvData)
    );

    always #5 clock = ~clock;

    // SpiBase model: MISO looped to MOSI, a few cycles of shifting per word.
    int spi_cnt;
    bit spi_stuck = 1'b0;
    always @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            spiReady    <= 1'b1;
            spiRecvData <= '0;
            spi_cnt     <= 0;
        end else if (spiStart && !spi_stuck) begin
            spiReady <= 1'b0;
            spi_cnt  <= 4;
        end else if (!spiReady && spi_cnt > 0) begin
            spi_cnt <= spi_cnt - 1;
            if (spi_cnt == 1) begin
                spiReady    <= 1'b1;
                spiRecvData <= spiSendData;
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Protocol monitor
    int   cyc = 0, starts = 0, ncs_falls = 0, rise_cyc = 0;
    bit   have_rise = 1'b0, chk_gap = 1'b0;
    logic ncs_prev = 1'b1, ready_prev = 1'b1, start_prev = 1'b0;
    always @(negedge clock) begin
        cyc++;
        if (!chk_gap) have_rise = 1'b0;
        else if (spiReady && !ready_prev) begin
            rise_cyc  = cyc;
            have_rise = 1'b1;
        end
        if (spiStart) begin
            starts++;
            check("cs_setup", 32'(ncs_prev), 0);
            check("start_single", 32'(start_prev), 0);
            if (have_rise) check("burst_gap", 32'(cyc - rise_cyc), 2);
        end
        if (!nCS && ncs_prev) ncs_falls++;
        ncs_prev   = nCS;
        ready_prev = spiReady;
        start_prev = spiStart;
    end

    logic [31:0] exp_q[$];

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic push_word(input logic [31:0] d, input bit accepted);
        sendData = d;
        push     = 1'b1;
        tick(1);
        push     = 1'b0;
        if (accepted) exp_q.push_back(d);
    endtask

    task automatic pop_check(input string name);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got %h expected no entry", name, recvData);
        end else begin
            e = exp_q.pop_front();
            check(name, recvData, e);
        end
        pop = 1'b1;
        tick(1);
        pop = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int n = 0;
        while (!(starts >= target && !busy) && n < budget) begin
            tick(1);
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got busy=%0d starts=%0d expected idle after %0d starts",
                     name, busy, starts, target);
        end
        check(name, 32'(starts), 32'(target));
    endtask

    task automatic wait_wait_done_state(input int target, input string name);
        int n = 0;
        while (!(starts >= target && !spiReady) && n < 100) begin
            tick(1);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got spiReady=%0d expected 0", name, spiReady);
        end
        tick(1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ncs"}, 32'(nCS), 1);
        check({tag, "_start"}, 32'(spiStart), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_sdata"}, spiSendData, 0);
        check({tag, "_rdata"}, recvData, 0);
        check({tag, "_s_flags"}, {28'b0, fullSendFifo, almostFullSendFifo, emptySendFifo,
                                  almostEmptySendFifo}, 32'b0011);
        check({tag, "_r_flags"}, {28'b0, fullRecvFifo, almostFullRecvFifo, emptyRecvFifo,
                                  almostEmptyRecvFifo}, 32'b0011);
    endtask

    typedef struct {
        logic [31:0] data;
        logic        full;
        logic        afull;
        logic        empty;
        logic        aempty;
    } vec_t;

    initial begin
        vec_t        tbl[9];
        int          base, f0;
        logic [31:0] held;

        tbl[0] = '{32'hA000_0001, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{32'hA000_0002, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{32'hA000_0003, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{32'hA000_0004, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{32'hA000_0005, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{32'hA000_0006, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{32'hA000_0007, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{32'hA000_0008, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[8] = '{32'hA000_0009, 1'b1, 1'b1, 1'b0, 1'b0};

        // Reset state
        tick(2);
        check_reset_values("rst");
        nReset = 1'b1;
        tick(1);

        // Single word with push/launch latency
        enable = 1'b1;
        push_word(32'h8000_BCA5, 1'b1);
        check("push_lat_empty_n1", 32'(emptySendFifo), 1);
        tick(1);
        check("push_lat_empty_n2", 32'(emptySendFifo), 0);
        check("push_lat_idle", 32'(busy), 0);
        tick(1);
        check("setup_busy", 32'(busy), 1);
        check("setup_ncs", 32'(nCS), 0);
        check("setup_nostart", 32'(spiStart), 0);
        tick(1);
        check("launch_start", 32'(spiStart), 1);
        tick(1);
        check("launch_sdata", spiSendData, 32'h8000_BCA5);
        wait_done(1, 100, "single_starts");
        check("single_ncs_high", 32'(nCS), 1);
        check("single_recv_empty_lag", 32'(emptyRecvFifo), 1);
        tick(1);
        check("single_recv_nonempty", 32'(emptyRecvFifo), 0);
        check("single_ncs_windows", 32'(ncs_falls), 1);
        pop_check("single_pop");
        tick(2);
        check("single_recv_empty", 32'(emptyRecvFifo), 1);

        // Burst of 4 prepared before enable
        enable = 1'b0;
        for (int i = 1; i <= 4; i++) push_word(32'(i), 1'b1);
        tick(2);
        base    = starts;
        f0      = ncs_falls;
        chk_gap = 1'b1;
        enable  = 1'b1;
        wait_done(base + 4, 300, "burst_starts");
        chk_gap = 1'b0;
        check("burst_one_window", 32'(ncs_falls - f0), 1);
        for (int i = 0; i < 4; i++) pop_check("burst_pop");

        // Full/empty boundaries, table-driven
        enable = 1'b0;
        tick(2);
        for (int i = 0; i < 9; i++) begin
            push_word(tbl[i].data, i < D);
            tick(1);
            check($sformatf("tbl%0d_full", i), 32'(fullSendFifo), 32'(tbl[i].full));
            check($sformatf("tbl%0d_afull", i), 32'(almostFullSendFifo), 32'(tbl[i].afull));
            check($sformatf("tbl%0d_empty", i), 32'(emptySendFifo), 32'(tbl[i].empty));
            check($sformatf("tbl%0d_aempty", i), 32'(almostEmptySendFifo), 32'(tbl[i].aempty));
        end
        held = recvData;
        pop  = 1'b1;
        tick(1);
        pop  = 1'b0;
        check("pop_empty_hold", recvData, held);
        check("pop_empty_flag", 32'(emptyRecvFifo), 1);
        base   = starts;
        enable = 1'b1;
        wait_done(base + D, 500, "full_drain_starts");
        tick(2);
        check("full_recv_full", 32'(fullRecvFifo), 1);
        check("full_recv_afull", 32'(almostFullRecvFifo), 1);
        check("full_send_empty", 32'(emptySendFifo), 1);
        for (int i = 0; i < D; i++) pop_check("full_pop");
        enable = 1'b0;
        tick(2);

        // Receive back-pressure: 10 words, no pops until the FSM stalls
        base   = starts;
        enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push_word(32'hB000_0000 + 32'(i), 1'b1);
            tick(1);
        end
        wait_done(base + D, 600, "bp_starts");
        tick(3);
        check("bp_no_extra", 32'(starts), 32'(base + D));
        check("bp_ncs", 32'(nCS), 1);
        check("bp_busy", 32'(busy), 0);
        check("bp_recv_full", 32'(fullRecvFifo), 1);
        check("bp_send_nonempty", 32'(emptySendFifo), 0);
        check("bp_send_aempty", 32'(almostEmptySendFifo), 1);
        pop_check("bp_pop_first");
        wait_done(base + D + 1, 100, "bp_resume");
        tick(2);
        check("bp_refull", 32'(fullRecvFifo), 1);
        for (int i = 0; i < D; i++) pop_check("bp_pop");
        wait_done(base + D + 2, 100, "bp_last");
        pop_check("bp_pop_last");
        enable = 1'b0;
        tick(2);

        // Enable drop during WAIT_DONE of word 1 of 3
        for (int i = 0; i < 3; i++) push_word(32'hC000_0010 + 32'(i), 1'b1);
        tick(2);
        base   = starts;
        f0     = ncs_falls;
        enable = 1'b1;
        wait_wait_done_state(base + 1, "drop_wait");
        enable = 1'b0;
        wait_done(base + 1, 100, "drop_one_word");
        tick(2);
        check("drop_ncs", 32'(nCS), 1);
        check("drop_recv_nonempty", 32'(emptyRecvFifo), 0);
        check("drop_send_nonempty", 32'(emptySendFifo), 0);
        check("drop_send_two", 32'(almostEmptySendFifo), 1);
        pop_check("drop_pop1");
        enable = 1'b1;
        wait_done(base + 3, 200, "drop_resume");
        check("drop_second_window", 32'(ncs_falls - f0), 2);
        pop_check("drop_pop2");
        pop_check("drop_pop3");
        enable = 1'b0;
        tick(2);

        // Stuck handshake holds WAIT_BUSY
        spi_stuck = 1'b1;
        enable    = 1'b1;
        push_word(32'hDEAD_0001, 1'b0);
        tick(30);
        check("stuck_busy", 32'(busy), 1);
        check("stuck_ncs", 32'(nCS), 0);
        check("stuck_nostart", 32'(spiStart), 0);
        nReset = 1'b0;
        tick(1);
        spi_stuck = 1'b0;
        enable    = 1'b0;
        nReset    = 1'b1;
        tick(2);
        check("stuck_recover_idle", 32'(busy), 0);

        // Asynchronous reset mid-burst, checked before any clock edge
        for (int i = 0; i < 3; i++) push_word(32'hE000_0020 + 32'(i), 1'b0);
        tick(2);
        base   = starts;
        enable = 1'b1;
        wait_wait_done_state(base + 1, "arst_wait");
        check("arst_pre_busy", 32'(busy), 1);
        #2 nReset = 1'b0;
        #1 check_reset_values("arst");
        exp_q.delete();
        enable = 1'b0;
        @(negedge clock);
        nReset = 1'b1;
        tick(3);
        check("arst_after_idle", 32'(busy), 0);
        check("arst_after_empty", 32'(emptySendFifo), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
